// File: rtl/madd_err_eval.sv
// Exhaustive error evaluator for an approximate multiply-add (A*B + C).
// Sweeps every {C,B,A} vector and accumulates error statistics of approx_res
// against the exact result through a two-stage capture/accumulate pipeline.
module madd_err_eval #(
    parameter int OPW = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [3*OPW-1:0]       stim_vec,
    input  logic [2*OPW-1:0]       approx_res,
    output logic                   busy,
    output logic                   done,
    output logic [3*OPW:0]         err_cnt,
    output logic [2*OPW-1:0]       max_abs_err,
    output logic [3*OPW-1:0]       wce_vec,
    output logic [5*OPW-1:0]       sum_abs_err
);
    localparam int RESW   = 2*OPW;
    localparam int VW     = 3*OPW;
    localparam int SW     = VW + RESW;
    localparam int STAGES = 2;
    localparam longint N  = longint'(1) << VW;
    localparam logic [VW-1:0] LAST = VW'(N - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state, state_nxt;
    logic              accept;
    // [0]: current cycle presents a vector, [1]: stage 1 holds a sample,
    // [2]: stage 2 accumulated a sample on the last edge
    logic [STAGES:0]   vld_pipe;
    logic [RESW-1:0]   exact, s1_approx, s1_exact, abs_err;
    logic [VW-1:0]     s1_vec;

    // Full-width exact reference; (2^OPW-1)^2 + 2^OPW-1 always fits in RESW
    assign exact = RESW'(stim_vec[OPW-1:0]) * RESW'(stim_vec[2*OPW-1:OPW])
                 + RESW'(stim_vec[3*OPW-1:2*OPW]);

    assign abs_err = (s1_approx >= s1_exact) ? (s1_approx - s1_exact)
                                             : (s1_exact - s1_approx);

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN) || (state == DRAIN);
    assign done   = (state == DONE);

    // Next-state decode; start only matters in IDLE/DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (stim_vec == LAST) state_nxt = DRAIN;
            // last sample has left stage 2 and nothing is behind it
            DRAIN:      if (vld_pipe[2] && !vld_pipe[1]) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Vector counter, capture stage, accumulate stage and valid shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            stim_vec    <= '0;
            vld_pipe    <= '0;
            s1_approx   <= '0;
            s1_exact    <= '0;
            s1_vec      <= '0;
            err_cnt     <= '0;
            max_abs_err <= '0;
            wce_vec     <= '0;
            sum_abs_err <= '0;
        end else if (accept) begin
            // fresh sweep: drop any stale pipeline contents and statistics
            stim_vec    <= '0;
            vld_pipe    <= (STAGES+1)'(1);
            err_cnt     <= '0;
            max_abs_err <= '0;
            wce_vec     <= '0;
            sum_abs_err <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], (state_nxt == RUN)};
            // counter wraps to 0 after LAST, which is also the idle value
            stim_vec <= (state == RUN) ? stim_vec + 1'b1 : '0;
            if (vld_pipe[0]) begin
                s1_approx <= approx_res;
                s1_exact  <= exact;
                s1_vec    <= stim_vec;
            end
            if (vld_pipe[1]) begin
                err_cnt     <= err_cnt + (VW+1)'(abs_err != '0);
                sum_abs_err <= sum_abs_err + SW'(abs_err);
                // strict compare keeps the earliest worst-case vector on ties
                if (abs_err > max_abs_err) begin
                    max_abs_err <= abs_err;
                    wce_vec     <= s1_vec;
                end
            end
        end
    end
endmodule

// File: tb/tb_madd_err_eval.sv
// Bench for madd_err_eval at OPW=3: a behavioural model gives the expected
// outputs for every cycle from the cycle count since the accepted start and
// prefix statistics of the sweep, plus literal pins for the known sweeps.
module tb_madd_err_eval;
    localparam int OPW  = 3;
    localparam int RESW = 2*OPW;
    localparam int VW   = 3*OPW;
    localparam int SW   = VW + RESW;
    localparam int N    = 1 << VW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [VW-1:0]   stim_vec;
    logic [RESW-1:0] approx_res;
    logic            busy, done;
    logic [VW:0]     err_cnt;
    logic [RESW-1:0] max_abs_err;
    logic [VW-1:0]   wce_vec;
    logic [SW-1:0]   sum_abs_err;

    madd_err_eval #(.OPW(OPW)) dut (
        .clk(clk), .rst(rst), .start(start), .stim_vec(stim_vec),
        .approx_res(approx_res), .busy(busy), .done(done), .err_cnt(err_cnt),
        .max_abs_err(max_abs_err), .wce_vec(wce_vec), .sum_abs_err(sum_abs_err)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;
    bit en = 1'b0;
    int k = -1;   // edges since the accepted start; -1 = idle after reset

    logic [RESW-1:0] lut [N];
    int     pf_err [N+1];
    int     pf_max [N+1];
    int     pf_wce [N+1];
    longint pf_sum [N+1];

    assign approx_res = lut[stim_vec];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exact_of(int v);
        return (v % 8) * ((v / 8) % 8) + v / 64;
    endfunction

    // mode 0 exact, 1 stuck at 0, 2 exact+1, 3 random, 4 small +/- offsets
    task automatic build(input int mode);
        int e, mx, wc, ec;
        longint sm;
        for (int v = 0; v < N; v++) begin
            case (mode)
                0: lut[v] = RESW'(exact_of(v));
                1: lut[v] = '0;
                2: lut[v] = RESW'(exact_of(v) + 1);
                3: lut[v] = RESW'($urandom);
                default: begin
                    int sel, off;
                    sel = $urandom_range(0, 6);
                    off = (sel < 2) ? 0 : (sel == 2) ? 1 : (sel == 3) ? 2 : (sel == 4) ? -1 : (sel == 5) ? -2 : 3;
                    lut[v] = RESW'(exact_of(v) + off);
                end
            endcase
        end
        mx = 0; wc = 0; ec = 0; sm = 0;
        pf_err[0] = 0; pf_max[0] = 0; pf_wce[0] = 0; pf_sum[0] = 0;
        for (int v = 0; v < N; v++) begin
            int a, x;
            a = int'(lut[v]);
            x = exact_of(v);
            e = (a >= x) ? a - x : x - a;
            if (e != 0) ec++;
            sm += e;
            if (e > mx) begin mx = e; wc = v; end
            pf_err[v+1] = ec; pf_max[v+1] = mx; pf_wce[v+1] = wc; pf_sum[v+1] = sm;
        end
    endtask

    // Track the sweep position from the inputs the DUT sees
    always @(posedge clk) begin
        if (rst) k = -1;
        else if (start && (k < 0 || k >= N + 2)) k = 0;
        else if (k >= 0 && k < N + 2) k = k + 1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (en) begin
            int n;
            n = (k <= 1) ? 0 : (k - 1 > N ? N : k - 1);
            chk("busy", 64'(busy), 64'(k >= 0 && k <= N + 1));
            chk("done", 64'(done), 64'(k >= N + 2));
            chk("stim_vec", 64'(stim_vec), 64'((k >= 0 && k < N) ? k : 0));
            chk("err_cnt", 64'(err_cnt), 64'(pf_err[n]));
            chk("max_abs_err", 64'(max_abs_err), 64'(pf_max[n]));
            chk("wce_vec", 64'(wce_vec), 64'(pf_wce[n]));
            chk("sum_abs_err", 64'(sum_abs_err), 64'(pf_sum[n]));
        end
    end

    task automatic do_rst();
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < N + 20) begin @(negedge clk); t++; end
        chk("done_timeout", 64'(done), 64'd1);
        repeat (3) @(negedge clk);   // statistics must stay frozen in DONE
    endtask

    task automatic final_chk(input string nm, input int ec, input int mx, input int wc, input int sm);
        chk({nm, "_err_cnt"}, 64'(err_cnt), 64'(ec));
        chk({nm, "_max"}, 64'(max_abs_err), 64'(mx));
        chk({nm, "_wce"}, 64'(wce_vec), 64'(wc));
        chk({nm, "_sum"}, 64'(sum_abs_err), 64'(sm));
    endtask

    initial begin
        build(0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);

        // exact circuit, then a restart straight from DONE
        pulse_start(); wait_done();
        final_chk("exact", 0, 0, 0, 0);
        pulse_start(); wait_done();
        final_chk("exact_again", 0, 0, 0, 0);

        // stuck at zero: pin the model and the DUT
        do_rst(); build(1);
        chk("model_stuck_err", 64'(pf_err[N]), 64'd497);
        chk("model_stuck_sum", 64'(pf_sum[N]), 64'd8064);
        pulse_start(); wait_done();
        final_chk("stuck0", 497, 56, 9'h1FF, 8064);

        // off by one everywhere
        do_rst(); build(2);
        pulse_start(); wait_done();
        final_chk("plus1", 512, 1, 0, 512);

        // random tables, plus a start pulse mid-RUN that must be ignored
        do_rst(); build(3);
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start(); wait_done();
        do_rst(); build(4);
        pulse_start(); wait_done();

        // reset mid-sweep then a fresh full sweep
        do_rst(); build(3);
        pulse_start();
        repeat (30) @(negedge clk);
        do_rst();
        repeat (2) @(negedge clk);
        pulse_start(); wait_done();

        // reset wins over start on the same edge
        @(negedge clk); #1 rst = 1'b1; start = 1'b1;
        @(negedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_over_start_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/madd_err_eval.md
MADD_ERR_EVAL -- requirements
Module: madd_err_eval

Interface
REQ-001 SHALL have parameter OPW, default 6, operand width of the multiply-add under test (A, B, C each OPW bits).
REQ-002 SHALL derive internal constants RESW = 2*OPW (result width) and N = 2^(3*OPW) (sweep length).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  sweep request, sampled on rising edge.
REQ-007 stim_vec  output  3*OPW  vector driven to the circuit under test: [OPW-1:0]=A, [2*OPW-1:OPW]=B, [3*OPW-1:2*OPW]=C.
REQ-008 approx_res  input  RESW  combinational result of the circuit under test for the current stim_vec.
REQ-009 busy  output  1  high in RUN and DRAIN.
REQ-010 done  output  1  high in DONE.
REQ-011 err_cnt  output  3*OPW+1  count of vectors with approx_res != exact.
REQ-012 max_abs_err  output  RESW  worst-case |approx_res - exact|.
REQ-013 wce_vec  output  3*OPW  first vector that produced max_abs_err.
REQ-014 sum_abs_err  output  3*OPW+RESW  sum of |approx_res - exact| over all vectors.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE or DONE with start=1 -> RUN next edge; clear all statistics outputs and the vector counter to 0 on that edge.
REQ-017 start SHALL be ignored in RUN and DRAIN.
REQ-018 In RUN, stim_vec SHALL equal the vector counter, which increments by 1 per cycle from 0 to N-1, with no gaps or repeats.
REQ-019 stim_vec SHALL be a registered output held at 0 outside RUN.
REQ-020 exact = A*B + C, computed at full RESW width without truncation (max (2^OPW-1)^2 + 2^OPW-1 < 2^RESW).
REQ-021 Stage 1: on the edge ending each RUN cycle, SHALL register approx_res, exact and stim_vec together.
REQ-022 Stage 2: on the next edge, SHALL compute abs_err = |approx - exact| as unsigned RESW bits, then update the statistics.
REQ-023 Stage 2 update: err_cnt += (abs_err != 0); sum_abs_err += abs_err.
REQ-024 Stage 2 update: if abs_err > max_abs_err (strictly greater), load max_abs_err and wce_vec; ties SHALL keep the earlier vector.
REQ-025 RUN -> DRAIN on the edge that presents the last vector (N-1) for capture.
REQ-026 DRAIN SHALL last until stage 2 has accumulated vector N-1, then go to DONE.
REQ-027 done SHALL rise exactly N+2 edges after the edge that samples start.
REQ-028 done SHALL stay high and statistics SHALL stay frozen in DONE until the next accepted start.
REQ-029 Accumulators SHALL NOT saturate or wrap; widths in REQ-011/014 cover worst case by construction.

Reset
REQ-030 rst=1 on an edge SHALL force IDLE, stim_vec=0, busy=0, done=0, err_cnt=0, max_abs_err=0, wce_vec=0, sum_abs_err=0, and SHALL clear the pipeline valids, regardless of state.
REQ-031 rst SHALL take priority over start on the same edge.
REQ-032 Reset mid-sweep SHALL discard partial results; no pipelined sample accumulates after reset.

Verification
REQ-033 approx_res driven by a bench exact model, OPW=6 -> done after 262146 cycles; err_cnt=0, max_abs_err=0, sum_abs_err=0, wce_vec=0.
REQ-034 approx_res stuck at 0, OPW=6 -> err_cnt=262017, max_abs_err=4032, wce_vec=18'h3FFFF, sum_abs_err=268369920.
REQ-035 approx_res = exact+1, OPW=6 -> err_cnt=262144, max_abs_err=1, wce_vec=0, sum_abs_err=262144.
REQ-036 OPW=2, start pulsed again mid-RUN -> ignored; done at edge 66 after first start; statistics match a single sweep.
REQ-037 OPW=2, rst asserted at cycle 30 of RUN, then start -> outputs all 0 after the reset edge; fresh sweep results equal an uninterrupted sweep.
